// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level round primitives for aes128_iter_core.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Rounds outside 1..10 only occur while the datapath output is being discarded.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
    return v;
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// Block-level valid/ready bus of aes128_iter_core: plaintext/key in, ciphertext out.
interface aes128_iter_core_if;
  logic            in_valid;
  logic            in_ready;
  aes_pkg::state_t in_text;
  aes_pkg::state_t in_key;
  logic            out_valid;
  logic            out_ready;
  aes_pkg::state_t out_text;

  modport master (output in_valid, in_text, in_key, out_ready,
                  input  in_ready, out_valid, out_text);
  modport slave  (input  in_valid, in_text, in_key, out_ready,
                  output in_ready, out_valid, out_text);
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from the current one and its round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  state_t     key_in,
  input  logic [7:0] rcon,
  output state_t     key_out
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_tmp, w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = key_in;
  // RotWord + SubWord of the last word, with rcon folded into the leading byte.
  assign w_tmp = {sbox(w_w3[23:16]) ^ rcon, sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])};
  assign w_n0 = w_w0 ^ w_tmp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;
  assign key_out = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, on-the-fly key schedule.
// Optional macro AES128_ITER_BLKCNT_EN adds the blk_cnt completed-block counter port.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES128_ITER_BLKCNT_EN
  output logic [31:0] blk_cnt,
`endif
  aes128_iter_core_if.slave bus
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  fsm_t       r_fsm, w_fsm_nxt;
  state_t     r_state, r_key, r_out_text;
  logic [3:0] r_rnd;
  logic       r_in_ready, r_out_valid;
  logic       w_accept, w_last, w_out_hs;
  state_t     w_st  [0:UNROLL];
  state_t     w_key [0:UNROLL];

  assign w_st[0]  = r_state;
  assign w_key[0] = r_key;

  // Round NUM_ROUNDS can only land on the last chained stage, so earlier stages always mix.
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [3:0] w_r;
    state_t     w_sr;
    assign w_r  = r_rnd + 4'(u);
    assign w_sr = shift_rows(sub_bytes(w_st[u]));
    aes_key_step u_key_step (.key_in(w_key[u]), .rcon(rcon_of(w_r)), .key_out(w_key[u+1]));
    if (UNROLL == NUM_ROUNDS && u == UNROLL - 1) begin : g_final
      assign w_st[u+1] = w_sr ^ w_key[u+1];
    end else if (u == UNROLL - 1) begin : g_tail
      assign w_st[u+1] = ((w_r == 4'(NUM_ROUNDS)) ? w_sr : mix_columns(w_sr)) ^ w_key[u+1];
    end else begin : g_mid
      assign w_st[u+1] = mix_columns(w_sr) ^ w_key[u+1];
    end
  end

  assign w_accept = (r_fsm == IDLE) && bus.in_valid && r_in_ready;
  assign w_last   = (r_rnd + 4'(UNROLL) - 4'd1) == 4'(NUM_ROUNDS);
  assign w_out_hs = (r_fsm == DONE) && bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = BUSY; else w_fsm_nxt = IDLE;
      BUSY:    if (w_last)   w_fsm_nxt = DONE; else w_fsm_nxt = BUSY;
      DONE:    if (w_out_hs) w_fsm_nxt = IDLE; else w_fsm_nxt = DONE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
    end
  end

  // Round state, key, round counter and ciphertext capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= 128'd0;
      r_key      <= 128'd0;
      r_rnd      <= 4'd0;
      r_out_text <= 128'd0;
    end else if (w_accept) begin
      r_state <= bus.in_text ^ bus.in_key;
      r_key   <= bus.in_key;
      r_rnd   <= 4'd1;
    end else if (r_fsm == BUSY) begin
      r_state <= w_st[UNROLL];
      r_key   <= w_key[UNROLL];
      r_rnd   <= r_rnd + 4'(UNROLL);
      if (w_last) r_out_text <= w_st[UNROLL];
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_text  = r_out_text;

`ifdef AES128_ITER_BLKCNT_EN
  logic [31:0] r_blk_cnt;

  // Completed output handshakes, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_blk_cnt <= 32'd0;
    else if (w_out_hs) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: UNROLL=1 main instance plus UNROLL=2/5/10 latency instances.
module tb_aes128_iter_core;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [7:0] tb_sbox [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_iter_core_if if1 ();
  aes128_iter_core_if if2 ();
  aes128_iter_core_if if5 ();
  aes128_iter_core_if if10 ();

`ifdef AES128_ITER_BLKCNT_EN
  logic [31:0] cnt1, cnt2, cnt5, cnt10;
`endif

  aes128_iter_core #(.UNROLL(1)) dut1 (.clk(clk), .rst_n(rst_n),
`ifdef AES128_ITER_BLKCNT_EN
    .blk_cnt(cnt1),
`endif
    .bus(if1));
  aes128_iter_core #(.UNROLL(2)) dut2 (.clk(clk), .rst_n(rst_n),
`ifdef AES128_ITER_BLKCNT_EN
    .blk_cnt(cnt2),
`endif
    .bus(if2));
  aes128_iter_core #(.UNROLL(5)) dut5 (.clk(clk), .rst_n(rst_n),
`ifdef AES128_ITER_BLKCNT_EN
    .blk_cnt(cnt5),
`endif
    .bus(if5));
  aes128_iter_core #(.UNROLL(10)) dut10 (.clk(clk), .rst_n(rst_n),
`ifdef AES128_ITER_BLKCNT_EN
    .blk_cnt(cnt10),
`endif
    .bus(if10));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Byte-array AES-128 reference using the S-box derived from GF inverses.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ tb_sbox[k[13]] ^ rc;
      k[1] = k[1] ^ tb_sbox[k[14]];
      k[2] = k[2] ^ tb_sbox[k[15]];
      k[3] = k[3] ^ tb_sbox[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = tb_sbox[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key, output int t_acc);
    int n;
    n = 0;
    while (!if1.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 136'(if1.in_ready), 136'(1));
    if1.in_text  = pt;
    if1.in_key   = key;
    if1.in_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!if1.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, lat2, lat5, lat10, t_acc, t_prev;
    logic [127:0] pt, key;
    logic [31:0]  e_cnt;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      tb_sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.in_text = 128'd0; if1.in_key = 128'd0;
    if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.in_text = 128'd0; if2.in_key = 128'd0;
    if5.in_valid = 1'b0; if5.out_ready = 1'b0; if5.in_text = 128'd0; if5.in_key = 128'd0;
    if10.in_valid = 1'b0; if10.out_ready = 1'b0; if10.in_text = 128'd0; if10.in_key = 128'd0;
    t_prev = 0;

    // Reset values, then in_ready rising one edge after release.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 136'({if1.in_ready, if1.out_valid, if1.out_text}), 136'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 136'(if1.in_ready), 136'(1));

    // FIPS-197 C.1 at UNROLL=1.
    send(C1_PT, C1_KEY, t_acc);
    wait_out(lat);
    chk("c1_latency", 136'(lat), 136'(10));
    chk("c1_text", 136'(if1.out_text), 136'(C1_CT));
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    chk("c1_after_hs", 136'({if1.out_valid, if1.in_ready}), 136'(2'b01));

    // FIPS-197 App. B on the unrolled instances in parallel.
    if2.in_text = B_PT;  if2.in_key = B_KEY;  if2.in_valid = 1'b1;
    if5.in_text = B_PT;  if5.in_key = B_KEY;  if5.in_valid = 1'b1;
    if10.in_text = B_PT; if10.in_key = B_KEY; if10.in_valid = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0; if5.in_valid = 1'b0; if10.in_valid = 1'b0;
    lat2 = -1; lat5 = -1; lat10 = -1;
    for (int n = 0; n < 20; n++) begin
      if (if2.out_valid && lat2 < 0) lat2 = n;
      if (if5.out_valid && lat5 < 0) lat5 = n;
      if (if10.out_valid && lat10 < 0) lat10 = n;
      @(negedge clk);
    end
    chk("u2_latency", 136'(lat2), 136'(5));
    chk("u5_latency", 136'(lat5), 136'(2));
    chk("u10_latency", 136'(lat10), 136'(1));
    chk("u2_text", 136'(if2.out_text), 136'(B_CT));
    chk("u5_text", 136'(if5.out_text), 136'(B_CT));
    chk("u10_text", 136'(if10.out_text), 136'(B_CT));
    if2.out_ready = 1'b1; if5.out_ready = 1'b1; if10.out_ready = 1'b1;
    @(negedge clk);
    if2.out_ready = 1'b0; if5.out_ready = 1'b0; if10.out_ready = 1'b0;
    chk("u10_after_hs", 136'({if10.out_valid, if10.in_ready}), 136'(2'b01));

    // Backpressure: output held, a stray in_valid pulse ignored.
    send(B_PT, B_KEY, t_acc);
    wait_out(lat);
    chk("b_latency", 136'(lat), 136'(10));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        if1.in_text = C1_PT; if1.in_key = C1_KEY; if1.in_valid = 1'b1;
      end else begin
        if1.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_hold", 136'({if1.out_valid, if1.in_ready, if1.out_text}), 136'({2'b10, B_CT}));
    end
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    chk("bp_release", 136'({if1.out_valid, if1.in_ready}), 136'(2'b01));

    // Reset in the middle of round 4 clears outputs immediately; C.1 works afterwards.
    send(C1_PT, C1_KEY, t_acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 136'({if1.out_valid, if1.in_ready, if1.out_text}), 136'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(C1_PT, C1_KEY, t_acc);
    wait_out(lat);
    chk("post_reset_latency", 136'(lat), 136'(10));
    chk("post_reset_text", 136'(if1.out_text), 136'(C1_CT));
    if1.out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back random blocks with out_ready held high.
    for (int b = 0; b < 8; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key, t_acc);
      if (b > 0) chk("b2b_period", 136'(t_acc - t_prev), 136'(12));
      t_prev = t_acc;
      wait_out(lat);
      chk("b2b_text", 136'(if1.out_text), 136'(ref_enc(pt, key)));
    end
    @(negedge clk);
    if1.out_ready = 1'b0;

`ifdef AES128_ITER_BLKCNT_EN
    // Counter wrap around 2^32.
    force dut1.r_blk_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut1.r_blk_cnt;
    if1.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send(C1_PT, C1_KEY, t_acc);
      wait_out(lat);
      @(negedge clk);
      e_cnt = 32'hFFFF_FFFF + 32'(b);
      chk("blk_cnt", 136'(cnt1), 136'(e_cnt));
    end
    if1.out_ready = 1'b0;
`else
    e_cnt = 32'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine with a valid/ready handshake on input and output.
- Runs the 10 AES rounds over multiple cycles, with UNROLL rounds per cycle, and expands the round keys on the fly.
- Sits between the block-level data path and the team's combinational round primitives: subbytes, shiftrows, mixcolumns, addroundkey.
- Successor to the single-round datapath: adds sequencing, final-round handling, key schedule and flow control.

Parameters:
- UNROLL, 1, rounds computed per clock. Legal values are 1, 2, 5, 10; any other value is an elaboration-time error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  core can accept a block.
- in_text  in  128  plaintext; byte 0 = [127:120], column-major per FIPS-197.
- in_key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_text  out  128  ciphertext.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - FSM goes to IDLE; round counter and rcon go to 0.
  - State and key registers clear to 0.
  - in_ready=0, out_valid=0, out_text=0.
  - in_ready rises in the first cycle after rst_n deasserts.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg <= in_text ^ in_key (round 0), key_reg <= in_key, rnd <= 1, go to BUSY.
  - in_text and in_key are sampled only on that accept edge.
- BUSY:
  - in_ready=0.
  - Each cycle applies UNROLL chained rounds r = rnd .. rnd+UNROLL-1.
  - Each round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey(K_r). Round 10 omits MixColumns.
  - K_r is produced by the chained key-step stage with RCON[r]; key_reg <= K_(rnd+UNROLL-1).
  - rnd <= rnd+UNROLL. When rnd+UNROLL-1 == 10: go to DONE and load out_text.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_text stays stable until the out_valid && out_ready edge, then go to IDLE with out_valid=0.
  - No bypass: a new block can be accepted one cycle after the handshake at the earliest.
- Latency: out_valid rises 10/UNROLL clock edges after the accept edge.
  - Throughput: one block per 10/UNROLL + 2 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-block aborts the block; no partial output is produced.
- All arithmetic is GF(2^8) with the modulus x^8+x^4+x^3+x+1. rnd is 4 bits and never exceeds 11.

Optional Feature:
- Macro: AES128_ITER_BLKCNT_EN.
- Defined:
  - Adds output port blk_cnt, 32 bits: the count of completed output handshakes.
  - Reset value 0; increments on each out_valid && out_ready edge; wraps 0xFFFFFFFF -> 0.
- Undefined: no port and no counter logic. Functional behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - 256-entry SBOX constant and sbox() function.
  - RCON[1:10] table (01,02,04,08,10,20,40,80,1b,36).
  - xtime() function.
  - typedef state_t (128 bits), typedef fsm_t {IDLE,BUSY,DONE}, constant NUM_ROUNDS = 10.
- Sub-module aes_key_step:
  - Inputs: key_in[127:0], rcon[7:0].
  - Output: key_out[127:0], computed as RotWord, SubWord, XOR with rcon, then XOR chain over 4 words.
  - Purely combinational; instantiated UNROLL times.
- Round datapath reuses the existing subbytes, shiftrows, mixcolumns and addroundkey modules. A generate-select skips mixcolumns for round 10.

Test Plan:
- FIPS-197 C.1, UNROLL=1: text 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_text 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 edges after accept.
- FIPS-197 App. B, UNROLL=2/5/10: text 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32, with latency 5/2/1 edges.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_text stable, in_ready=0 and a pulsed in_valid ignored; release -> IDLE next cycle.
- Reset mid-block: assert rst_n=0 at BUSY round 4 -> out_valid/out_text/in_ready become 0 immediately; after release, the C.1 vector still gives the correct result.
- Back-to-back: 8 random blocks with out_ready=1 compared against a reference model -> all match, with a 12-cycle period at UNROLL=1.
- With AES128_ITER_BLKCNT_EN: preload the counter to 0xFFFFFFFE by force, complete 3 blocks -> blk_cnt reads 0xFFFFFFFF, 0, 1.
